// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state codes, timing defaults and width helper for the button click decoder
// Purpose: state encoding (3-bit codes visible on o_state), default ms timing constants,
//          and the ms counter width derived from the longest timeout.
// Ports:   none (package).
// Config:  BTN_AUTOREPEAT_EN is consumed by btn_click_decoder; nothing here depends on it.
package btn_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_HELD   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_PRESS1 = ST_PRESS1,
        S_WAIT2  = ST_WAIT2,
        S_PRESS2 = ST_PRESS2,
        S_HELD   = ST_HELD
    } btn_state_e;

    localparam int TICK_DIV_DEF  = 100_000;
    localparam int LONG_MS_DEF   = 1000;
    localparam int DCLICK_MS_DEF = 300;
    localparam int REPEAT_MS_DEF = 200;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    localparam int MS_W = $clog2(max3(LONG_MS_DEF, DCLICK_MS_DEF, REPEAT_MS_DEF) + 1);

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running divider producing a one-clk tick every DIV clks
// Purpose: 1 ms time base shared by the watch blocks.
// Ports:   clk    - system clock
//          reset  - asynchronous active-low reset (0 = reset), clears the divider
//          o_tick - high for one clk every DIV clks (first tick DIV clks after reset release)
module ms_tick_gen
    import btn_pkg::*;
#(
    parameter int DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        o_tick = (cnt_q == CW'(DIV - 1));
        cnt_d  = o_tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_click_decoder.sv
// rtl/btn_click_decoder.sv - classifies a debounced button level into single/double/long events
// Purpose: edge register, click FSM, saturating ms counter and registered one-clk event pulses.
// Ports:   clk      - system clock
//          reset    - asynchronous active-low reset (0 = reset)
//          i_btn    - debounced button level, clk-synchronous, 1 = pressed
//          o_single - one-clk pulse: single click
//          o_double - one-clk pulse: double click
//          o_long   - one-clk pulse: long press (and auto-repeat)
//          o_state  - current FSM state code
// Config:  BTN_AUTOREPEAT_EN - when defined, HELD re-fires o_long every REPEAT_MS ticks.
module btn_click_decoder
    import btn_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int LONG_MS   = LONG_MS_DEF,
    parameter int DCLICK_MS = DCLICK_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn,
    output logic       o_single,
    output logic       o_double,
    output logic       o_long,
    output logic [2:0] o_state
);

    // Sized from the actual parameters so overridden timings still fit.
    localparam int CW = $clog2(max3(LONG_MS, DCLICK_MS, REPEAT_MS) + 1);

    logic          tick;
    logic          btn_q;
    logic          rise;
    logic          fall;
    btn_state_e    state_q;
    btn_state_e    state_d;
    logic [CW-1:0] ms_cnt_q;
    logic [CW-1:0] ms_cnt_d;
    logic          single_q;
    logic          single_d;
    logic          double_q;
    logic          double_d;
    logic          long_q;
    logic          long_d;
    logic          long_to;
    logic          dclick_to;
    logic          ms_restart;
`ifdef BTN_AUTOREPEAT_EN
    logic          repeat_to;
`endif

    ms_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (tick)
    );

    always_comb begin
        rise      = i_btn & ~btn_q;
        fall      = ~i_btn & btn_q;
        long_to   = tick && (ms_cnt_q == CW'(LONG_MS - 1));
        dclick_to = tick && (ms_cnt_q == CW'(DCLICK_MS - 1));
`ifdef BTN_AUTOREPEAT_EN
        repeat_to = tick && (ms_cnt_q == CW'(REPEAT_MS - 1));
`endif
    end

    // Edges are tested before timeouts in every state, so a coincident
    // edge always wins and suppresses the timeout event.
    always_comb begin
        state_d    = state_q;
        single_d   = 1'b0;
        double_d   = 1'b0;
        long_d     = 1'b0;
        ms_restart = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) state_d = S_PRESS1;
            end
            S_PRESS1: begin
                if (fall) begin
                    state_d = S_WAIT2;
                end else if (long_to) begin
                    long_d  = 1'b1;
                    state_d = S_HELD;
                end
            end
            S_WAIT2: begin
                if (rise) begin
                    state_d = S_PRESS2;
                end else if (dclick_to) begin
                    single_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_PRESS2: begin
                // A held second press still reports the double click, not a long press.
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (long_to) begin
                    double_d = 1'b1;
                    state_d  = S_HELD;
                end
            end
            S_HELD: begin
                if (fall) begin
                    state_d = S_IDLE;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (repeat_to) begin
                    long_d     = 1'b1;
                    ms_restart = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Every state change restarts timing; the count saturates instead of wrapping.
        if ((state_d != state_q) || ms_restart) begin
            ms_cnt_d = '0;
        end else if (tick && (ms_cnt_q != '1)) begin
            ms_cnt_d = ms_cnt_q + CW'(1);
        end else begin
            ms_cnt_d = ms_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q    <= 1'b0;
            state_q  <= S_IDLE;
            ms_cnt_q <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            btn_q    <= i_btn;
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
        end
    end

    assign o_single = single_q;
    assign o_double = double_q;
    assign o_long   = long_q;
    assign o_state  = state_q;

endmodule
